// File: rtl/pid_core_param.sv
// pid_core_param: multi-cycle signed PID controller with run-time gains.
// A sample accepted on sample_valid runs through ERR -> MUL -> SUM -> OUT.
// The control word appears with a one-cycle out_valid pulse four cycles
// after the accepting edge.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   sample_valid    new setpoint/feedback sample; gains captured with it
//   setpoint        target value (unsigned, DATA_W)
//   feedback        measured value (unsigned, DATA_W)
//   kp, ki, kd      unsigned gains (COEF_W), FRAC_W fraction bits
//   clear           synchronous flush of integral/prev_error, aborts work
//   busy            computation in flight, samples ignored
//   out_valid       one-cycle pulse, control_signal updated
//   control_signal  saturated unsigned control word
//   saturated       last output was clamped
//
// Optional feature: define PID_ANTI_WINDUP_EN for conditional-integration
// anti-windup (integral holds when the output clamps in the error's direction).
module pid_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  input  logic [COEF_W-1:0] kp,
  input  logic [COEF_W-1:0] ki,
  input  logic [COEF_W-1:0] kd,
  input  logic              clear,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] control_signal,
  output logic              saturated
);

  localparam int unsigned E_W = DATA_W + 1;   // error width
  localparam int unsigned D_W = DATA_W + 2;   // error-difference width
  localparam int unsigned W_W = ACC_W + 2;    // headroom for three-term sums

  localparam logic signed [W_W-1:0]   SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [W_W-1:0]   SAT_LO = -SAT_HI;
  localparam logic signed [ACC_W-1:0] Y_MAX  = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [DATA_W-1:0]        sp_q, sp_d, fb_q, fb_d;
  logic [COEF_W-1:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [E_W-1:0]    e_q, e_d;
  logic signed [D_W-1:0]    d_q, d_d;
  logic signed [ACC_W-1:0]  p_q, p_d, ii_q, ii_d, dt_q, dt_d;
  logic signed [ACC_W-1:0]  integ_q, integ_d;
  logic signed [E_W-1:0]    prev_err_q, prev_err_d;
  logic [DATA_W-1:0]        cs_q, cs_d;
  logic                     sat_q, sat_d, ov_q, ov_d, busy_q, busy_d;

  logic signed [E_W-1:0]    e_c;
  logic signed [D_W-1:0]    d_c;
  logic signed [ACC_W-1:0]  e_a, d_a, i_cand, s_sum, s_sh;
  logic                     clamp_hi, clamp_lo, hold_int;
  logic [DATA_W-1:0]        y_c;

  // Symmetric saturation to +/-(2^(ACC_W-1)-1).
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [W_W-1:0] x);
    if (x > SAT_HI)      return SAT_HI[ACC_W-1:0];
    else if (x < SAT_LO) return SAT_LO[ACC_W-1:0];
    else                 return x[ACC_W-1:0];
  endfunction

  function automatic logic signed [W_W-1:0] ext_w(input logic signed [ACC_W-1:0] x);
    return {{2{x[ACC_W-1]}}, x};
  endfunction

  // Next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    fb_d       = fb_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    e_d        = e_q;
    d_d        = d_q;
    p_d        = p_q;
    ii_d       = ii_q;
    dt_d       = dt_q;
    integ_d    = integ_q;
    prev_err_d = prev_err_q;
    cs_d       = cs_q;
    sat_d      = sat_q;

    // Inputs are unsigned, so zero-extend before the signed subtract.
    e_c = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
    d_c = $signed({e_c[E_W-1], e_c}) - $signed({prev_err_q[E_W-1], prev_err_q});
    e_a = ACC_W'(e_q);
    d_a = ACC_W'(d_q);

    i_cand   = sat_acc(ext_w(integ_q) + ext_w(ii_q));
    s_sum    = sat_acc(ext_w(p_q) + ext_w(i_cand) + ext_w(dt_q));
    s_sh     = s_sum >>> FRAC_W;
    clamp_lo = s_sh[ACC_W-1];
    clamp_hi = !clamp_lo && (s_sh > Y_MAX);
    if (clamp_lo)      y_c = '0;
    else if (clamp_hi) y_c = '1;
    else               y_c = s_sh[DATA_W-1:0];

`ifdef PID_ANTI_WINDUP_EN
    // Stop integrating while the output is pinned in the error's direction.
    hold_int = (clamp_hi && !e_q[E_W-1] && (e_q != '0)) || (clamp_lo && e_q[E_W-1]);
`else
    hold_int = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_OUT: begin
        if (sample_valid) begin
          sp_d    = setpoint;
          fb_d    = feedback;
          kp_d    = kp;
          ki_d    = ki;
          kd_d    = kd;
          state_d = S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        e_d     = e_c;
        d_d     = d_c;
        state_d = S_MUL;
      end
      S_MUL: begin
        p_d     = ACC_W'($signed({1'b0, kp_q})) * e_a;
        ii_d    = ACC_W'($signed({1'b0, ki_q})) * e_a;
        dt_d    = ACC_W'($signed({1'b0, kd_q})) * d_a;
        state_d = S_SUM;
      end
      S_SUM: begin
        // Output is always formed from i_cand; only the commit may hold.
        integ_d    = hold_int ? integ_q : i_cand;
        prev_err_d = e_q;
        cs_d       = y_c;
        sat_d      = clamp_lo | clamp_hi;
        state_d    = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear aborts in-flight work but leaves the last output word intact.
    if (clear) begin
      state_d    = S_IDLE;
      integ_d    = '0;
      prev_err_d = '0;
      cs_d       = cs_q;
      sat_d      = sat_q;
    end

    ov_d   = (state_d == S_OUT);
    busy_d = (state_d == S_ERR) || (state_d == S_MUL) || (state_d == S_SUM);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      fb_q       <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      e_q        <= '0;
      d_q        <= '0;
      p_q        <= '0;
      ii_q       <= '0;
      dt_q       <= '0;
      integ_q    <= '0;
      prev_err_q <= '0;
      cs_q       <= '0;
      sat_q      <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      fb_q       <= fb_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      e_q        <= e_d;
      d_q        <= d_d;
      p_q        <= p_d;
      ii_q       <= ii_d;
      dt_q       <= dt_d;
      integ_q    <= integ_d;
      prev_err_q <= prev_err_d;
      cs_q       <= cs_d;
      sat_q      <= sat_d;
      ov_q       <= ov_d;
      busy_q     <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign out_valid      = ov_q;
  assign control_signal = cs_q;
  assign saturated      = sat_q;

endmodule

// File: doc/pid_core_param.md
# pid_core_param

Parametrised, multi-cycle signed PID controller. It is the next generation of the single-channel 8-bit PID in the TinyTapeout top-level. It accepts a setpoint/feedback sample on a valid strobe and computes error, integral and derivative terms with run-time gains over a fixed 4-cycle pipeline. It returns a saturated, unsigned control word with a one-cycle valid pulse and sits between the `ui_in`/`uio_in` pads and `uo_out`.

## Interface
- `DATA_W`, 8: width of setpoint, feedback and control_signal (unsigned)
- `COEF_W`, 8: width of kp/ki/kd (unsigned)
- `FRAC_W`, 8: arithmetic right shift applied to the PID sum (gain fraction bits)
- `ACC_W`, 24: signed width of integral accumulator and PID sum
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sample_valid`  in  1  new sample present
- `setpoint`  in  DATA_W  target value
- `feedback`  in  DATA_W  measured value
- `kp`, `ki`, `kd`  in  COEF_W each  gains, captured with the sample
- `clear`  in  1  synchronous flush of controller state
- `busy`  out  1  computation in flight; samples ignored
- `out_valid`  out  1  one-cycle pulse, control_signal updated
- `control_signal`  out  DATA_W  saturated output
- `saturated`  out  1  last output was clamped (valid with out_valid, held until next)

## Operation
- FSM states, in order: IDLE, ERR, MUL, SUM, OUT.
  - IDLE: `sample_valid` moves to ERR and registers setpoint, feedback and gains.
  - ERR: e = signed(setpoint) − signed(feedback), DATA_W+1 bits. d = e − prev_error.
  - MUL: P = kp·e, I_inc = ki·e, D = kd·d. Products are signed and sign-extended to ACC_W.
  - SUM: I_cand = integral + I_inc, saturating at ±(2^(ACC_W−1)−1). S = P + I_cand + D, saturating likewise.
  - OUT: y = S >>> FRAC_W, clamped to [0, 2^DATA_W−1]. Sets `control_signal`, `saturated` and `out_valid`. Commits the integral and prev_error ← e. Returns to IDLE.
- `sample_valid` in any state other than IDLE or OUT is ignored; samples are not queued.
- The first sample after reset or clear uses prev_error = 0, so D = kd·e.
- `clear` zeroes integral and prev_error, aborts any computation to IDLE without `out_valid`, and leaves `control_signal` unchanged.
- `clear` wins over a simultaneous `sample_valid`.
- Gains change only at sample acceptance. Port changes mid-computation have no effect.

## Timing
- Reset values: `control_signal`=0, `out_valid`=0, `busy`=0, `saturated`=0, integral=0, prev_error=0, state IDLE.
- Acceptance edge T: `busy`=1 from T+1 through T+3. `out_valid`=1 and `busy`=0 at T+4.
- A sample presented during the OUT cycle (T+4) is accepted there. Sustained throughput is one sample per 4 cycles.
- Reset asserted mid-computation returns every register to its reset value immediately. No `out_valid` is produced.

## Configuration
- `PID_ANTI_WINDUP_EN` defined: conditional-integration anti-windup.
  - If y was clamped high and e > 0, or clamped low and e < 0, the integral keeps its old value instead of I_cand.
  - The output of that sample is still computed from I_cand.
- Not defined: the integral always commits I_cand; only ACC_W saturation limits it.

## Test plan
- Proportional only (kp=0x10, ki=kd=0), default params:
  - sp=200, fb=72 → e=128, out_valid at T+4, control_signal=8, saturated=0.
  - sp=10, fb=200 → e=−190, sum −3040 → control_signal=0, saturated=1.
- Integral (ki=0x80, kp=kd=0), three samples with sp=fb+4 → control_signal 2, 4, 6.
  - Then `clear`, then the same sample → 2.
- Derivative (kd=0x40, kp=ki=0), after reset:
  - sp=8, fb=0 → 2.
  - Repeat same sample → 0.
  - sp=0, fb=0 → 0 (d=−8, clamped), saturated=1.
- Anti-windup (ki=0xFF, kp=kd=0): two samples sp=255, fb=0 → 254, then 255 with saturated=1. Then sample sp=0, fb=100:
  - with `PID_ANTI_WINDUP_EN` → 154
  - without it → 255, saturated=1
- Protocol:
  - `sample_valid` held high continuously → exactly one out_valid per 4 cycles.
  - Samples during busy are ignored.
  - `clear` at T+2 → no out_valid.
  - `rst_n` low at T+3 → all outputs 0 within the same cycle.
